sub_serial: RTL and testbench

Bit-serial subtractor in the obfuscated-control arithmetic family. It is the inverse-operation companion to the serial adder. It accepts two key-scrambled W-bit operands, unscrambles them with fixed inversion masks, and computes difference = A − B mod 2^W LSB-first, one bit per clock. The difference and the final borrow are presented in parallel. The FSM carries the family's decoy states so that the control encoding does not reveal the datapath schedule.

---
 rtl/sub_serial.sv | 134 +++++++++++++
 tb/tb_sub_serial.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// -----------------------------------------------------------------------------
// sub_serial
//
// Bit-serial subtractor. Two key-scrambled operands are unscrambled with fixed
// XOR masks on the load edge. The design then computes A - B mod 2^WIDTH one
// bit per clock, LSB first. The difference and the final borrow are presented
// in parallel once the operation completes.
//
// The control FSM includes decoy states that only add delay cycles. As a
// result, the state encoding does not expose the datapath schedule.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous, active-high reset
//   en         : start request in IDLE, acknowledge/return in DONE
//   a          : scrambled minuend   (plain A = a ^ KEY_A), sampled on load
//   b          : scrambled subtrahend (plain B = b ^ KEY_B), sampled on load
//   out        : difference register, filled MSB-first from the serial result
//   borrow_out : final borrow (1 when A < B), valid in DONE
//   done       : high while the FSM is in DONE
//   busy       : high in every state other than IDLE and DONE
// -----------------------------------------------------------------------------
module sub_serial #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] KEY_A = WIDTH'(32'h5E),
    parameter logic [WIDTH-1:0] KEY_B = WIDTH'(32'h58)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SUB  = 3'd1;
    localparam logic [2:0] S_DONE = 3'd2;
    localparam logic [2:0] S_DLY0 = 3'd3;
    localparam logic [2:0] S_DLY1 = 3'd4;
    localparam logic [2:0] S_DLY2 = 3'd5;
    localparam logic [2:0] S_DLY3 = 3'd6;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [2:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] out_q,    out_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    // One full-subtractor cell working on the current LSBs.
    logic a0, b0, diff_bit, borrow_next;

    assign a0          = a_q[0];
    assign b0          = b_q[0];
    assign diff_bit    = a0 ^ b0 ^ borrow_q;
    assign borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = en ? S_DLY0 : S_IDLE;
            S_DLY0:  state_d = S_SUB;
            S_SUB:   state_d = (cnt_q == CNT_LAST) ? S_DLY1 : S_SUB;
            S_DLY1:  state_d = S_DONE;
            S_DONE:  state_d = en ? S_IDLE : S_DONE;
            S_DLY2:  state_d = S_DLY0;
            S_DLY3:  state_d = S_DLY1;
            default: state_d = S_IDLE;  // encoding 7 is illegal
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: load in IDLE with en, shift in SUB, hold everywhere else
    // -------------------------------------------------------------------------
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        if (state_q == S_IDLE && en) begin
            a_d      = a ^ KEY_A;
            b_d      = b ^ KEY_B;
            out_d    = '0;
            borrow_d = 1'b0;
            cnt_d    = '0;
        end else if (state_q == S_SUB) begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            out_d    = {diff_bit, out_q[WIDTH-1:1]};
            borrow_d = borrow_next;
            cnt_d    = cnt_q + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out        = out_q;
    assign borrow_out = borrow_q;
    assign done       = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_sub_serial.sv
// -----------------------------------------------------------------------------
// tb_sub_serial
//
// Directed testbench for sub_serial (WIDTH=8, default keys). Each task covers
// one scenario and compares the DUT outputs against hand-computed values.
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_sub_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       borrow_out;
    logic       done;
    logic       busy;

    int total = 0;
    int bad   = 0;

    sub_serial #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .a          (a),
        .b          (b),
        .out        (out),
        .borrow_out (borrow_out),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Pulse en for one edge (the load edge). The task returns at the falling
    // edge right after the load.
    task automatic start_op(input logic [7:0] sa, input logic [7:0] sb);
        @(negedge clk);
        a  = sa;
        b  = sb;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Count clock edges until done is high. The wait is bounded, so a hung
    // DUT returns a count that the caller's comparison rejects.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Acknowledge DONE and return to IDLE.
    task automatic ack_done;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        b   = '0;
        #1;
        total++;
        if ({out, borrow_out, done, busy} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: out=%h borrow=%b done=%b busy=%b, want all 0",
                     out, borrow_out, done, busy);
        end
        total++;
        if (dut.state_q !== 3'd0) begin
            bad++;
            $display("FAIL reset_state: got %0d want 0", dut.state_q);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int cyc;
        start_op(8'h7B, 8'h4B);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_after_load: busy=%b done=%b want 1/0", busy, done);
        end
        wait_done(cyc);
        total++;
        if (cyc != 10) begin
            bad++;
            $display("FAIL basic_latency: got %0d want 10", cyc);
        end
        total++;
        if (out !== 8'h12 || borrow_out !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: out=%h borrow=%b busy=%b want 12/0/0",
                     out, borrow_out, busy);
        end
        ack_done();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== 8'h12) begin
            bad++;
            $display("FAIL basic_ack: done=%b busy=%b out=%h want 0/0/12", done, busy, out);
        end
    endtask

    task automatic test_underflow;
        int cyc;
        start_op(8'h5E, 8'h59);
        wait_done(cyc);
        total++;
        if (out !== 8'hFF || borrow_out !== 1'b1) begin
            bad++;
            $display("FAIL underflow: out=%h borrow=%b want ff/1", out, borrow_out);
        end
        ack_done();
    endtask

    task automatic test_equal_en_toggle;
        int cyc;
        start_op(8'hDE, 8'hD8);
        // Toggle en through DLY0/SUB. It must be ignored there.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en = ~en;
        end
        en = 1'b0;
        wait_done(cyc);
        total++;
        if (cyc != 4 || out !== 8'h00 || borrow_out !== 1'b0) begin
            bad++;
            $display("FAIL equal_en_toggle: cyc=%0d out=%h borrow=%b want 4/00/0",
                     cyc, out, borrow_out);
        end
        ack_done();
    endtask

    task automatic test_reset_mid;
        int cyc;
        start_op(8'h7B, 8'h4B);
        repeat (4) @(negedge clk);  // three SUB steps done, fourth is next
        total++;
        if (out !== 8'h40) begin
            bad++;
            $display("FAIL mid_partial: out=%h want 40", out);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({out, borrow_out, done, busy} !== 11'd0 || dut.state_q !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset: out=%h borrow=%b done=%b busy=%b state=%0d want 0",
                     out, borrow_out, done, busy, dut.state_q);
        end
        @(negedge clk);
        rst = 1'b0;
        start_op(8'h7B, 8'h4B);
        wait_done(cyc);
        total++;
        if (cyc != 10 || out !== 8'h12 || borrow_out !== 1'b0) begin
            bad++;
            $display("FAIL mid_restart: cyc=%0d out=%h borrow=%b want 10/12/0",
                     cyc, out, borrow_out);
        end
    endtask

    // Entered while still in DONE from the previous task (out = 12).
    task automatic test_done_hold;
        int held_ok = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done !== 1'b1 || out !== 8'h12 || borrow_out !== 1'b0) held_ok = 0;
        end
        total++;
        if (held_ok != 1) begin
            bad++;
            $display("FAIL done_hold: done=%b out=%h borrow=%b want 1/12/0 for 20 clocks",
                     done, out, borrow_out);
        end
        ack_done();
    endtask

    task automatic test_back_to_back;
        int cyc;
        @(negedge clk);
        a  = 8'h7B;
        b  = 8'h4B;
        en = 1'b1;
        @(negedge clk);             // load edge has passed
        a  = 8'hA1;                 // plain 0xFF
        b  = 8'h59;                 // plain 0x01
        wait_done(cyc);
        total++;
        if (cyc != 10 || out !== 8'h12) begin
            bad++;
            $display("FAIL b2b_first: cyc=%0d out=%h want 10/12", cyc, out);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== 8'h12) begin
            bad++;
            $display("FAIL b2b_idle: done=%b busy=%b out=%h want 0/0/12", done, busy, out);
        end
        @(negedge clk);
        en = 1'b0;
        total++;
        if (busy !== 1'b1 || out !== 8'h00) begin
            bad++;
            $display("FAIL b2b_reload: busy=%b out=%h want 1/00", busy, out);
        end
        wait_done(cyc);
        total++;
        if (cyc != 10 || out !== 8'hFE || borrow_out !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: cyc=%0d out=%h borrow=%b want 10/fe/0",
                     cyc, out, borrow_out);
        end
        ack_done();
    endtask

    task automatic test_decoy;
        start_op(8'h7B, 8'h4B);     // now in DLY0 with the operands loaded
        force dut.state_q = 3'd5;
        #1 release dut.state_q;
        @(negedge clk);
        total++;
        if (dut.state_q !== 3'd3) begin
            bad++;
            $display("FAIL decoy5_step1: state=%0d want 3", dut.state_q);
        end
        @(negedge clk);
        total++;
        if (dut.state_q !== 3'd1) begin
            bad++;
            $display("FAIL decoy5_step2: state=%0d want 1", dut.state_q);
        end
        repeat (8) @(negedge clk);
        total++;
        if (dut.state_q !== 3'd4) begin
            bad++;
            $display("FAIL decoy5_dly1: state=%0d want 4", dut.state_q);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || out !== 8'h12 || borrow_out !== 1'b0) begin
            bad++;
            $display("FAIL decoy5_result: done=%b out=%h borrow=%b want 1/12/0",
                     done, out, borrow_out);
        end
        ack_done();

        force dut.state_q = 3'd6;
        #1 release dut.state_q;
        @(negedge clk);
        total++;
        if (dut.state_q !== 3'd4) begin
            bad++;
            $display("FAIL decoy6_step1: state=%0d want 4", dut.state_q);
        end
        @(negedge clk);
        total++;
        if (dut.state_q !== 3'd2 || done !== 1'b1 || out !== 8'h12) begin
            bad++;
            $display("FAIL decoy6_step2: state=%0d done=%b out=%h want 2/1/12",
                     dut.state_q, done, out);
        end
        ack_done();

        force dut.state_q = 3'd7;
        #1 release dut.state_q;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL illegal_flags: busy=%b done=%b want 1/0", busy, done);
        end
        @(negedge clk);
        total++;
        if (dut.state_q !== 3'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL illegal_recover: state=%0d busy=%b want 0/0", dut.state_q, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_equal_en_toggle();
        test_reset_mid();
        test_done_hold();
        test_back_to_back();
        test_decoy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
